// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath: decodes opcode/funct and
// sequences fetch, decode, execute, memory and writeback with all datapath controls.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | PC <= PC+4 and IR <= mem[PC]
// DCD    | decode opcode/funct, no writes
// EXE    | ALU operation for arithmetic, logic and address calculation
// MEM_RD | data memory read for lw
// MEM_WR | data memory write for sw
// WB     | register file writeback, suppressed after an addi overflow
// BR     | beq compare and conditional PC update
// JMP    | j/jal/jr PC update, jal also links into $31
module mc_ctrl #(
  parameter bit NONE_ILLEGAL_TO_FETCH = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWr,
  output logic       DMWr,
  output logic [1:0] NPCOp,
  output logic       ALUSrcB,
  output logic [1:0] ExtOp,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic [3:0] AluCtrl,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DCD    = 3'd1,
    EXE    = 3'd2,
    MEM_RD = 3'd3,
    MEM_WR = 3'd4,
    WB     = 3'd5,
    BR     = 3'd6,
    JMP    = 3'd7
  } state_t;

  localparam logic [3:0] ALU_ADDU = 4'b0000;
  localparam logic [3:0] ALU_SUBU = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_BB   = 4'b0011;
  localparam logic [3:0] ALU_ADD  = 4'b0101;
  localparam logic [3:0] ALU_LT   = 4'b0110;

  state_t cur, nxt;
  logic   ov_q;

  logic is_r, i_addu, i_subu, i_slt, i_jr;
  logic i_ori, i_lui, i_addi, i_lw, i_sw, i_beq, i_j, i_jal;
  logic go_exe, go_jmp;

  assign is_r   = (opcode == 6'b000000);
  assign i_addu = is_r && (funct == 6'b100001);
  assign i_subu = is_r && (funct == 6'b100011);
  assign i_slt  = is_r && (funct == 6'b101010);
  assign i_jr   = is_r && (funct == 6'b001000);
  assign i_ori  = (opcode == 6'b001101);
  assign i_lui  = (opcode == 6'b001111);
  assign i_addi = (opcode == 6'b001000);
  assign i_lw   = (opcode == 6'b100011);
  assign i_sw   = (opcode == 6'b101011);
  assign i_beq  = (opcode == 6'b000100);
  assign i_j    = (opcode == 6'b000010);
  assign i_jal  = (opcode == 6'b000011);

  assign go_exe = i_addu | i_subu | i_slt | i_ori | i_lui | i_addi | i_lw | i_sw;
  assign go_jmp = i_j | i_jal | i_jr;
  assign state  = cur;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur  <= FETCH;
      ov_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == EXE) ov_q <= i_addi & overflow;
    end
  end

  // ALU setup shared by EXE and the memory states that must hold the address.
  logic [3:0] exe_alu;
  logic       exe_srcb;
  logic [1:0] exe_ext;

  always_comb begin
    exe_alu  = ALU_ADDU;
    exe_srcb = 1'b0;
    exe_ext  = 2'b00;
    if (i_subu) exe_alu = ALU_SUBU;
    if (i_slt)  exe_alu = ALU_LT;
    if (i_ori) begin
      exe_alu  = ALU_OR;
      exe_srcb = 1'b1;
    end
    if (i_lui) begin
      exe_alu  = ALU_BB;
      exe_srcb = 1'b1;
      exe_ext  = 2'b10;
    end
    if (i_addi) begin
      exe_alu  = ALU_ADD;
      exe_srcb = 1'b1;
      exe_ext  = 2'b01;
    end
    if (i_lw || i_sw) begin
      exe_srcb = 1'b1;
      exe_ext  = 2'b01;
    end
  end

  always_comb begin
    nxt     = cur;
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RegWr   = 1'b0;
    DMWr    = 1'b0;
    NPCOp   = 2'b00;
    ALUSrcB = 1'b0;
    ExtOp   = 2'b00;
    RegDst  = 2'b00;
    WDSel   = 2'b00;
    AluCtrl = 4'b0000;
    case (cur)
      FETCH: begin
        PCWr = 1'b1;
        IRWr = 1'b1;
        nxt  = DCD;
      end
      DCD: begin
        if (go_exe)                     nxt = EXE;
        else if (i_beq)                 nxt = BR;
        else if (go_jmp)                nxt = JMP;
        else if (NONE_ILLEGAL_TO_FETCH) nxt = FETCH;
        else                            nxt = DCD;
      end
      EXE: begin
        AluCtrl = exe_alu;
        ALUSrcB = exe_srcb;
        ExtOp   = exe_ext;
        nxt     = i_lw ? MEM_RD : (i_sw ? MEM_WR : WB);
      end
      MEM_RD: begin
        AluCtrl = exe_alu;
        ALUSrcB = exe_srcb;
        ExtOp   = exe_ext;
        nxt     = WB;
      end
      MEM_WR: begin
        AluCtrl = exe_alu;
        ALUSrcB = exe_srcb;
        ExtOp   = exe_ext;
        DMWr    = 1'b1;
        nxt     = FETCH;
      end
      WB: begin
        RegWr  = ~ov_q;
        RegDst = is_r ? 2'b01 : 2'b00;
        WDSel  = i_lw ? 2'b01 : 2'b00;
        nxt    = FETCH;
      end
      BR: begin
        AluCtrl = ALU_SUBU;
        NPCOp   = 2'b01;
        PCWr    = zero;
        nxt     = FETCH;
      end
      JMP: begin
        PCWr  = 1'b1;
        NPCOp = i_jr ? 2'b11 : 2'b10;
        if (i_jal) begin
          RegWr  = 1'b1;
          RegDst = 2'b10;
          WDSel  = 2'b10;
        end
        nxt = FETCH;
      end
      default: nxt = FETCH;
    endcase
    if (!rst_n) begin
      PCWr    = 1'b0;
      IRWr    = 1'b0;
      RegWr   = 1'b0;
      DMWr    = 1'b0;
      NPCOp   = 2'b00;
      ALUSrcB = 1'b0;
      ExtOp   = 2'b00;
      RegDst  = 2'b00;
      WDSel   = 2'b00;
      AluCtrl = 4'b0000;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction is expanded into its expected
// per-cycle control trace and compared against the DUT cycle by cycle.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       PCWr, IRWr, RegWr, DMWr, ALUSrcB;
  logic [1:0] NPCOp, ExtOp, RegDst, WDSel;
  logic [3:0] AluCtrl;
  logic [2:0] state;

  mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .zero(zero), .overflow(overflow),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .DMWr(DMWr),
    .NPCOp(NPCOp), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .RegDst(RegDst),
    .WDSel(WDSel), .AluCtrl(AluCtrl), .state(state)
  );

  always #5 clk = ~clk;

  logic [19:0] got;
  assign got = {state, PCWr, IRWr, RegWr, DMWr, NPCOp, ALUSrcB, ExtOp, RegDst, WDSel, AluCtrl};

  typedef struct packed {
    logic        z;
    logic        ov;
    logic [19:0] e;
  } step_t;

  step_t q[$];
  int    n_tests, n_fail;
  string names[14] = '{"addu", "subu", "slt", "jr", "ori", "lui", "addi",
                       "lw", "sw", "beq", "j", "jal", "bad_op", "bad_funct"};

  task automatic chk_eq(input string tag, input logic [19:0] act, input logic [19:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [19:0] mk(input logic [2:0] st, input logic pc, input logic ir,
                                     input logic rw, input logic dw, input logic [1:0] npc,
                                     input logic sb, input logic [1:0] ext, input logic [1:0] rd,
                                     input logic [1:0] wd, input logic [3:0] alu);
    return {st, pc, ir, rw, dw, npc, sb, ext, rd, wd, alu};
  endfunction

  task automatic push(input logic z, input logic ov, input logic [19:0] e);
    step_t s;
    s.z  = z;
    s.ov = ov;
    s.e  = e;
    q.push_back(s);
  endtask

  // Expected trace of one instruction: every cycle from FETCH until the return to FETCH.
  task automatic build(input int kind, output logic [5:0] op, output logic [5:0] fn);
    logic [19:0] idle, exe_e;
    logic        z, ov;
    q.delete();
    idle = mk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0);
    op = 6'b000000;
    fn = 6'($urandom_range(0, 63));
    push(rb(), rb(), mk(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0));
    push(rb(), rb(), idle);
    case (kind)
      0, 1, 2: begin
        fn = (kind == 0) ? 6'b100001 : (kind == 1) ? 6'b100011 : 6'b101010;
        push(rb(), rb(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00,
                            (kind == 0) ? 4'h0 : (kind == 1) ? 4'h1 : 4'h6));
        push(rb(), rb(), mk(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 2'b00, 4'h0));
      end
      3: begin
        fn = 6'b001000;
        push(rb(), rb(), mk(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0));
      end
      4, 5: begin
        op = (kind == 4) ? 6'b001101 : 6'b001111;
        push(rb(), rb(), mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1,
                            (kind == 4) ? 2'b00 : 2'b10, 2'b00, 2'b00,
                            (kind == 4) ? 4'h2 : 4'h3));
        push(rb(), rb(), mk(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0));
      end
      6: begin
        op = 6'b001000;
        ov = rb();
        push(rb(), ov, mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 4'h5));
        push(rb(), rb(), mk(3'd5, 1'b0, 1'b0, !ov, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0));
      end
      7, 8: begin
        op = (kind == 7) ? 6'b100011 : 6'b101011;
        exe_e = mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 4'h0);
        push(rb(), rb(), exe_e);
        if (kind == 7) begin
          push(rb(), rb(), mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 4'h0));
          push(rb(), rb(), mk(3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b01, 4'h0));
        end else begin
          push(rb(), rb(), mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b01, 2'b00, 2'b00, 4'h0));
        end
      end
      9: begin
        op = 6'b000100;
        z  = rb();
        push(z, rb(), mk(3'd6, z, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 4'h1));
      end
      10: begin
        op = 6'b000010;
        push(rb(), rb(), mk(3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 4'h0));
      end
      11: begin
        op = 6'b000011;
        push(rb(), rb(), mk(3'd7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 2'b10, 2'b10, 4'h0));
      end
      12: op = 6'b111111;
      default: begin
        while (fn == 6'b100001 || fn == 6'b100011 || fn == 6'b101010 || fn == 6'b001000)
          fn = 6'($urandom_range(0, 63));
      end
    endcase
  endtask

  initial begin
    int          kind, abort_at;
    logic [5:0]  op, fn;
    rst_n    = 1'b0;
    opcode   = 6'b0;
    funct    = 6'b0;
    zero     = 1'b0;
    overflow = 1'b0;
    n_tests  = 0;
    n_fail   = 0;

    repeat (3) begin
      @(posedge clk); #1;
      zero     = rb();
      overflow = rb();
      @(negedge clk);
      chk_eq("reset", got, 20'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      kind = (n < 14) ? n : int'($urandom_range(0, 13));
      if (n == 14) kind = 6;
      build(kind, op, fn);
      opcode   = op;
      funct    = fn;
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, q.size() - 1)) : -1;
      if (n == 14) abort_at = 2;
      for (int k = 0; k < q.size(); k++) begin
        zero     = q[k].z;
        overflow = q[k].ov;
        if (k == abort_at) begin
          rst_n = 1'b0;
          @(negedge clk);
          chk_eq($sformatf("%s_rst[%0d]", names[kind], k), got, {q[k].e[19:17], 17'h0});
          @(posedge clk); #1;
          rst_n = 1'b1;
          break;
        end
        @(negedge clk);
        chk_eq($sformatf("%s[%0d]", names[kind], k), got, q[k].e);
        @(posedge clk); #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
